// File: rtl/lfsr_counter.sv
// lfsr_counter: Fibonacci or Galois LFSR with a step counter that measures
// the distance from the last applied seed. It emits a one-cycle wrap pulse
// when the sequence returns to that seed. A zero seed on load is replaced by
// SEED and flagged with a lockup pulse, so the all-zero state is unreachable.
module lfsr_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             out_bit,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lockup
);

  // State that follows the update rules below.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic             w_hit_ref;
  logic             w_seed_zero;

  // Fibonacci form: the parity of the tapped bits shifts in at bit 0.
  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[WIDTH-2:0], fb};
  endfunction

  // Galois form: shift left, and fold the bit that falls out of the MSB
  // back into every tapped position.
  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
  endfunction

  // Successor of the current state in the selected form, and its comparison
  // against the reference seed.
  always_comb begin
    w_next      = (MODE == 0) ? fib_step(r_q) : galois_step(r_q);
    w_hit_ref   = (w_next == r_ref);
    w_seed_zero = (seed_in == '0);
  end

  // State update, with priority reset > load > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= SEED;
      r_ref    <= SEED;
      r_count  <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else if (load) begin
      // A zero seed would park the LFSR forever, so substitute SEED.
      if (w_seed_zero) begin
        r_q      <= SEED;
        r_ref    <= SEED;
        r_lockup <= 1'b1;
      end else begin
        r_q      <= seed_in;
        r_ref    <= seed_in;
        r_lockup <= 1'b0;
      end
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_q      <= w_next;
      r_lockup <= 1'b0;
      if (w_hit_ref) begin
        r_count <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= r_count + WIDTH'(1);
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end
  end

  assign q       = r_q;
  assign out_bit = r_q[WIDTH-1];
  assign count   = r_count;
  assign wrap    = r_wrap;
  assign lockup  = r_lockup;

endmodule

// File: tb/tb_lfsr_counter.sv
// tb_lfsr_counter: directed bench for lfsr_counter. Instance A uses the
// default Fibonacci configuration; instance B uses the Galois form with
// TAPS = 8'h1D.
module tb_lfsr_counter;

  logic       clk;
  logic       a_reset, a_en, a_load;
  logic [7:0] a_seed, a_q, a_count;
  logic       a_out, a_wrap, a_lock;
  logic       b_reset, b_en, b_load;
  logic [7:0] b_seed, b_q, b_count;
  logic       b_out, b_wrap, b_lock;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [0:255];
  bit         seen[0:255];

  lfsr_counter u_a (
    .clk(clk), .reset(a_reset), .en(a_en), .load(a_load), .seed_in(a_seed),
    .q(a_q), .out_bit(a_out), .count(a_count), .wrap(a_wrap), .lockup(a_lock)
  );

  lfsr_counter #(.WIDTH(8), .TAPS(8'h1D), .MODE(1), .SEED(8'h01)) u_b (
    .clk(clk), .reset(b_reset), .en(b_en), .load(b_load), .seed_in(b_seed),
    .q(b_q), .out_bit(b_out), .count(b_count), .wrap(b_wrap), .lockup(b_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [7:0] fib_exp [0:7];
    logic [7:0] gal_exp [0:11];
    logic [7:0] hold_q, hold_c, max_c;
    int         repeats;

    fib_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    gal_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h1D, 8'h3A, 8'h74, 8'hE8};

    a_reset = 1'b1; a_en = 1'b1; a_load = 1'b1; a_seed = 8'h77;
    b_reset = 1'b1; b_en = 1'b0; b_load = 1'b0; b_seed = 8'h00;
    tick();
    // reset wins over load and en
    check("rst_q", a_q, 8'h01);
    check("rst_count", a_count, 8'h00);
    check("rst_wrap", 8'(a_wrap), 8'h00);
    check("rst_lockup", 8'(a_lock), 8'h00);
    check("rst_outbit", 8'(a_out), 8'h00);

    // first steps after reset
    a_reset = 1'b0; a_load = 1'b0; a_en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("fib_q%0d", k), a_q, fib_exp[k]);
      check($sformatf("fib_cnt%0d", k), a_count, 8'(k));
    end
    check("fib_outbit_8E", 8'(a_out), 8'h01);

    // hold with en low
    a_en = 1'b0;
    tick(); tick(); tick();
    check("hold_q", a_q, 8'h8E);
    check("hold_count", a_count, 8'h07);
    check("hold_wrap", 8'(a_wrap), 8'h00);

    // reset toggled between edges has no effect until an edge samples it
    #2 a_reset = 1'b1;
    #1;
    check("async_q", a_q, 8'h8E);
    check("async_count", a_count, 8'h07);
    a_reset = 1'b0;
    tick();
    check("async_q_after", a_q, 8'h8E);

    // full period from reset
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[8'h01] = 1'b1;
    repeats = 0;
    max_c = 8'h00;
    a_en = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255) begin
        check($sformatf("per_wrap%0d", k), 8'(a_wrap), 8'h00);
        if (seen[a_q]) repeats++;
        seen[a_q] = 1'b1;
        if (a_count > max_c) max_c = a_count;
      end
    end
    check("per_no_repeat", 8'(repeats), 8'h00);
    check("per_no_zero", 8'(seen[0]), 8'h00);
    check("per_max_count", max_c, 8'd254);
    check("per_q", a_q, 8'h01);
    check("per_wrap", 8'(a_wrap), 8'h01);
    check("per_count", a_count, 8'h00);
    a_en = 1'b0;
    tick();
    check("per_wrap_drop", 8'(a_wrap), 8'h00);
    check("per_q_hold", a_q, 8'h01);

    // load takes precedence over en and performs no step
    a_load = 1'b1; a_en = 1'b1; a_seed = 8'h5A;
    tick();
    check("ld_q", a_q, 8'h5A);
    check("ld_count", a_count, 8'h00);
    check("ld_wrap", 8'(a_wrap), 8'h00);
    check("ld_lockup", 8'(a_lock), 8'h00);
    a_load = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255) check($sformatf("ld_wrap%0d", k), 8'(a_wrap), 8'h00);
    end
    check("ld_per_q", a_q, 8'h5A);
    check("ld_per_wrap", 8'(a_wrap), 8'h01);
    check("ld_per_count", a_count, 8'h00);

    // zero seed falls back to SEED with a lockup pulse
    a_load = 1'b1; a_seed = 8'h00;
    tick();
    check("zs_q", a_q, 8'h01);
    check("zs_lockup", 8'(a_lock), 8'h01);
    check("zs_count", a_count, 8'h00);
    check("zs_wrap", 8'(a_wrap), 8'h00);
    a_load = 1'b0;
    tick();
    check("zs_lockup_drop", 8'(a_lock), 8'h00);
    check("zs_q1", a_q, 8'h02);
    check("zs_cnt1", a_count, 8'h01);
    tick();
    check("zs_q2", a_q, 8'h04);

    // reset mid-sequence with en held high
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    check("mid_count100", a_count, 8'd100);
    a_reset = 1'b1;
    tick();
    check("mid_rst_q", a_q, 8'h01);
    check("mid_rst_count", a_count, 8'h00);
    a_reset = 1'b0;
    tick();
    check("mid_q", a_q, 8'h02);
    check("mid_count", a_count, 8'h01);
    a_en = 1'b0;

    // Galois instance: hand-computed start, then full period recorded
    b_reset = 1'b0; b_en = 1'b1;
    seq[0] = b_q;
    check("gal_q0", b_q, 8'h01);
    for (int k = 1; k <= 255; k++) begin
      tick();
      seq[k] = b_q;
      if (k < 12) check($sformatf("gal_q%0d", k), b_q, gal_exp[k]);
      if (k < 255) check($sformatf("gal_wrap%0d", k), 8'(b_wrap), 8'h00);
    end
    check("gal_per_q", b_q, 8'h01);
    check("gal_per_wrap", 8'(b_wrap), 8'h01);
    check("gal_per_count", b_count, 8'h00);

    // same sequence at half rate
    b_en = 1'b0; b_reset = 1'b1; tick(); b_reset = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      hold_q = seq[k-1];
      hold_c = (k == 1) ? 8'h00 : 8'(k - 1);
      b_en = 1'b0;
      tick();
      check($sformatf("half_hold_q%0d", k), b_q, hold_q);
      check($sformatf("half_hold_c%0d", k), b_count, hold_c);
      b_en = 1'b1;
      tick();
      check($sformatf("half_q%0d", k), b_q, seq[k]);
    end
    check("half_wrap", 8'(b_wrap), 8'h01);
    b_en = 1'b0;
    tick();
    check("half_wrap_drop", 8'(b_wrap), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
